// File: rtl/mem_slave_sram_if.sv
// Request/response bus between a memory master and mem_slave_sram.
// Signal names carry the slave-side _i/_o suffixes so both ends read the same.
interface mem_slave_sram_if #(
   parameter int ADDRESS_SIZE = 64,
   parameter int DATA_WIDTH   = 64
);

   logic [ADDRESS_SIZE-1:0] address_i;
   logic [DATA_WIDTH-1:0]   data_wdata_i;
   logic                    data_req_i;
   logic                    data_we_i;
   logic [DATA_WIDTH/8-1:0] data_be_i;
   logic                    data_gnt_o;
   logic                    data_rvalid_o;
   logic [DATA_WIDTH-1:0]   data_rdata_o;

   modport master (
      output address_i,
      output data_wdata_i,
      output data_req_i,
      output data_we_i,
      output data_be_i,
      input  data_gnt_o,
      input  data_rvalid_o,
      input  data_rdata_o
   );

   modport slave (
      input  address_i,
      input  data_wdata_i,
      input  data_req_i,
      input  data_we_i,
      input  data_be_i,
      output data_gnt_o,
      output data_rvalid_o,
      output data_rdata_o
   );

endinterface

// File: rtl/mem_slave_sram.sv
// Single-port SRAM slave with fixed-latency in-order responses and byte-enabled writes.
// Define MEM_SLAVE_GNT_STALL_EN to insert pseudo-random grant stalls from an 8-bit LFSR.
module mem_slave_sram #(
   parameter int ADDRESS_SIZE = 64,
   parameter int DATA_WIDTH   = 64,
   parameter int NUM_WORDS    = 1024,
   parameter int LATENCY      = 2
) (
   input logic             clk_i,
   input logic             rst_ni,
   mem_slave_sram_if.slave bus
);

   localparam int BYTES    = DATA_WIDTH / 8;
   localparam int OFFSET_W = $clog2(BYTES);
   localparam int IDX_W    = $clog2(NUM_WORDS);

   logic                               gnt;
   logic                               wr_en;
   logic [IDX_W-1:0]                   word_idx;
   logic [DATA_WIDTH-1:0]              rd_word;
   logic [DATA_WIDTH-1:0]              mem_q [NUM_WORDS];
   logic [LATENCY-1:0]                 valid_q, valid_d;
   logic [LATENCY-1:0][DATA_WIDTH-1:0] rdata_q, rdata_d;
   logic                               unused_addr;

   // Bits below the byte offset and above the index are ignored, so addresses wrap.
   assign word_idx    = bus.address_i[OFFSET_W +: IDX_W];
   assign unused_addr = ^bus.address_i;

`ifdef MEM_SLAVE_GNT_STALL_EN
   logic [7:0] lfsr_q, lfsr_d;

   always_comb begin
      lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) lfsr_q <= 8'hA5;
      else         lfsr_q <= lfsr_d;
   end

   assign gnt = bus.data_req_i & (lfsr_q[1:0] != 2'b00);
`else
   assign gnt = bus.data_req_i;
`endif

   assign bus.data_gnt_o = gnt;
   assign wr_en          = gnt & bus.data_we_i;
   assign rd_word        = mem_q[word_idx];

   // NOTE: storage has no reset branch so it maps onto an SRAM macro; contents survive rst_ni.
   always_ff @(posedge clk_i) begin
      if (wr_en) begin
         for (int b = 0; b < BYTES; b++) begin
            if (bus.data_be_i[b]) mem_q[word_idx][8*b +: 8] <= bus.data_wdata_i[8*b +: 8];
         end
      end
   end

   // NOTE: combinational blocks use blocking '=' with every output defaulted first, so no latch is inferred.
   always_comb begin
      valid_d    = '0;
      rdata_d    = '0;
      valid_d[0] = gnt;
      rdata_d[0] = (gnt && !bus.data_we_i) ? rd_word : '0;
      for (int s = 1; s < LATENCY; s++) begin
         valid_d[s] = valid_q[s-1];
         rdata_d[s] = rdata_q[s-1];
      end
   end

   // NOTE: sequential blocks use non-blocking '<=' so every stage samples the pre-edge value.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         valid_q <= '0;
         rdata_q <= '0;
      end else begin
         valid_q <= valid_d;
         rdata_q <= rdata_d;
      end
   end

   assign bus.data_rvalid_o = valid_q[LATENCY-1];
   assign bus.data_rdata_o  = rdata_q[LATENCY-1];

endmodule

// File: tb/tb_mem_slave_sram.sv
// Directed bench for mem_slave_sram: a scoreboard queue pairs every grant with its response.
// Define MEM_SLAVE_GNT_STALL_EN for both bench and RTL to exercise the stall LFSR.
module tb_mem_slave_sram;

   localparam int ADDRESS_SIZE = 64;
   localparam int DATA_WIDTH   = 64;
   localparam int NUM_WORDS    = 1024;
   localparam int LATENCY      = 2;

   typedef struct {
      logic [63:0] rdata;
      int          gcyc;
   } sb_t;

   logic        clk_i = 1'b0;
   logic        rst_ni;
   sb_t         sb[$];
   int          tests = 0;
   int          fails = 0;
   int          cyc = 0;
   int          last_gcyc = 0;
   int          rv_seen = 0;
   int          streak = 0;
   int          max_streak = 0;
   int          gcount = 0;
   int          g[8];
   logic        granted;
   logic [63:0] cur_exp;
   logic [7:0]  lfsr;

   always #5 clk_i = ~clk_i;

   mem_slave_sram_if #(.ADDRESS_SIZE(ADDRESS_SIZE), .DATA_WIDTH(DATA_WIDTH)) bus ();

   mem_slave_sram #(
      .ADDRESS_SIZE(ADDRESS_SIZE),
      .DATA_WIDTH  (DATA_WIDTH),
      .NUM_WORDS   (NUM_WORDS),
      .LATENCY     (LATENCY)
   ) dut (
      .clk_i (clk_i),
      .rst_ni(rst_ni),
      .bus   (bus)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed 0x%h expected 0x%h", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] lfsr_next(input logic [7:0] l);
      return {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
   endfunction

   // One clock: sample outputs on the falling edge, then step past the rising edge.
   task automatic tick();
      logic exp_gnt;
      sb_t  e;
      @(negedge clk_i);
      if (bus.data_rvalid_o === 1'b1) begin
         rv_seen++;
         streak++;
         if (streak > max_streak) max_streak = streak;
         if (sb.size() == 0) begin
            check("unexpected_rvalid", 64'(bus.data_rvalid_o), 64'd0);
         end else begin
            e = sb.pop_front();
            check("rdata", bus.data_rdata_o, e.rdata);
            check("latency", 64'(cyc - e.gcyc), 64'(LATENCY));
         end
      end else begin
         streak = 0;
         check("rvalid_low", 64'(bus.data_rvalid_o), 64'd0);
         check("idle_rdata", bus.data_rdata_o, 64'd0);
      end
`ifdef MEM_SLAVE_GNT_STALL_EN
      exp_gnt = bus.data_req_i & (lfsr[1:0] != 2'b00);
`else
      exp_gnt = bus.data_req_i;
`endif
      check("gnt", 64'(bus.data_gnt_o), 64'(exp_gnt));
      granted = (bus.data_gnt_o === 1'b1);
      if (granted) begin
         last_gcyc = cyc;
         sb.push_back('{rdata: (bus.data_we_i ? 64'd0 : cur_exp), gcyc: cyc});
      end
      @(posedge clk_i);
      cyc++;
      lfsr = rst_ni ? lfsr_next(lfsr) : 8'hA5;
      #1;
   endtask

   task automatic do_req(input logic we, input logic [63:0] addr, input logic [63:0] wdata,
                         input logic [7:0] be, input logic [63:0] exp);
      bus.data_req_i   = 1'b1;
      bus.data_we_i    = we;
      bus.address_i    = addr;
      bus.data_wdata_i = wdata;
      bus.data_be_i    = be;
      cur_exp          = exp;
      granted          = 1'b0;
      for (int i = 0; i < 16 && !granted; i++) tick();
      check("gnt_within_bound", 64'(granted), 64'd1);
      bus.data_req_i = 1'b0;
   endtask

   task automatic wr(input logic [63:0] addr, input logic [63:0] wdata, input logic [7:0] be);
      do_req(1'b1, addr, wdata, be, 64'd0);
   endtask

   task automatic rd(input logic [63:0] addr, input logic [63:0] exp);
      do_req(1'b0, addr, 64'd0, 8'h00, exp);
   endtask

   task automatic idle(input int n);
      bus.data_req_i = 1'b0;
      repeat (n) tick();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      rst_ni           = 1'b0;
      bus.data_req_i   = 1'b0;
      bus.data_we_i    = 1'b0;
      bus.address_i    = '0;
      bus.data_wdata_i = '0;
      bus.data_be_i    = '0;
      cur_exp          = '0;
      granted          = 1'b0;
      lfsr             = 8'hA5;

      // Reset state
      repeat (2) tick();
      check("reset_rvalid", 64'(bus.data_rvalid_o), 64'd0);
      check("reset_rdata", bus.data_rdata_o, 64'd0);
      rst_ni = 1'b1;
      idle(2);

      // Full write then back-to-back read of the same word
      wr(64'h10, 64'hDEADBEEF_CAFEF00D, 8'hFF);
      rd(64'h10, 64'hDEADBEEF_CAFEF00D);
      idle(4);

      // Partial writes, including be = 0 and a sparse byte pattern
      wr(64'h18, 64'h11223344_55667788, 8'hFF);
      wr(64'h18, 64'hAAAAAAAA_BBBBBBBB, 8'h0F);
      rd(64'h18, 64'h11223344_BBBBBBBB);
      wr(64'h20, 64'h01234567_89ABCDEF, 8'hFF);
      wr(64'h20, 64'hFFFFFFFF_FFFFFFFF, 8'h00);
      rd(64'h20, 64'h01234567_89ABCDEF);
      wr(64'h28, 64'h0, 8'hFF);
      wr(64'h28, 64'hA1A2A3A4_A5A6A7A8, 8'hA5);
      rd(64'h28, 64'hA100A300_00A600A8);
      idle(4);

      // Streaming: eight back-to-back reads
      for (int i = 0; i < 8; i++) wr(64'h100 + 64'(8 * i), {32'hC0DE_0000 + 32'(i), ~32'(i)}, 8'hFF);
      idle(3);
      max_streak = 0;
      for (int i = 0; i < 8; i++) begin
         rd(64'h100 + 64'(8 * i), {32'hC0DE_0000 + 32'(i), ~32'(i)});
         g[i] = last_gcyc;
      end
      idle(LATENCY + 2);
`ifndef MEM_SLAVE_GNT_STALL_EN
      for (int i = 1; i < 8; i++) check("stream_grant_spacing", 64'(g[i] - g[0]), 64'(i));
      check("stream_rvalid_run", 64'(max_streak), 64'd8);
`endif

      // Address wrap
      wr(64'h2000, 64'h1, 8'hFF);
      rd(64'h0, 64'h1);
      wr(64'hFFFF_FFFF_FFFF_FFF8, 64'h5A, 8'hFF);
      rd(64'h1FF8, 64'h5A);
      idle(4);

      // Reset one cycle after a read grant drops the response
      rd(64'h10, 64'hDEADBEEF_CAFEF00D);
      rst_ni = 1'b0;
      sb.delete();
      lfsr    = 8'hA5;
      rv_seen = 0;
      idle(3);
      check("midreset_rvalid", 64'(bus.data_rvalid_o), 64'd0);
      check("midreset_rdata", bus.data_rdata_o, 64'd0);
      rst_ni = 1'b1;
      idle(LATENCY + 3);
      check("no_rvalid_after_reset", 64'(rv_seen), 64'd0);
      rd(64'h10, 64'hDEADBEEF_CAFEF00D);
      idle(4);

`ifdef MEM_SLAVE_GNT_STALL_EN
      // Request held for 32 cycles; grant follows the bench LFSR
      bus.data_req_i   = 1'b1;
      bus.data_we_i    = 1'b0;
      bus.address_i    = 64'h10;
      cur_exp          = 64'hDEADBEEF_CAFEF00D;
      gcount           = 0;
      rv_seen          = 0;
      repeat (32) begin
         tick();
         if (granted) gcount++;
      end
      idle(LATENCY + 2);
      check("stall_rvalid_count", 64'(rv_seen), 64'(gcount));
`endif

      check("scoreboard_empty", 64'(sb.size()), 64'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/mem_slave_sram.md
MEM_SLAVE_SRAM -- requirements
Module: mem_slave_sram

Interface
REQ-001 SHALL have parameter ADDRESS_SIZE, default 64, request address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 64, data width in bits; legal values are 32 and 64.
REQ-003 SHALL have parameter NUM_WORDS, default 1024, storage depth in DATA_WIDTH words; power of two, minimum 2.
REQ-004 SHALL have parameter LATENCY, default 2, cycles from grant to rvalid; legal range 1..4.
REQ-005 SHALL have port clk_i, input, 1, single clock; all state updates on its rising edge.
REQ-006 SHALL have port rst_ni, input, 1, reset: asynchronous, active-low.
REQ-007 SHALL have port address_i, input, ADDRESS_SIZE, byte address of the request.
REQ-008 SHALL have port data_wdata_i, input, DATA_WIDTH, write data.
REQ-009 SHALL have port data_req_i, input, 1, request valid.
REQ-010 SHALL have port data_we_i, input, 1, 1 = write, 0 = read.
REQ-011 SHALL have port data_be_i, input, DATA_WIDTH/8, byte enables for writes.
REQ-012 SHALL have port data_gnt_o, output, 1, request accepted this cycle.
REQ-013 SHALL have port data_rvalid_o, output, 1, response valid.
REQ-014 SHALL have port data_rdata_o, output, DATA_WIDTH, read data.

Function
REQ-015 SHALL accept a request in any cycle where data_req_i and data_gnt_o are both 1 (a grant cycle); requests are not queued, and the master holds inputs stable until granted.
REQ-016 SHALL compute data_gnt_o combinationally from data_req_i and the stall state; data_gnt_o SHALL be 0 whenever data_req_i is 0.
REQ-017 SHALL form the word index from the address bits above the byte offset (log2(DATA_WIDTH/8) low bits dropped), truncated to log2(NUM_WORDS) bits; out-of-range addresses wrap silently.
REQ-018 SHALL update, on a granted write, only the bytes whose data_be_i bit is 1, at the end of the grant cycle; be = 0 leaves storage unchanged but still produces a response.
REQ-019 SHALL sample read data on a granted read from storage as it is at the start of the grant cycle, so a read granted in the cycle after a write to the same word returns the new data.
REQ-020 SHALL assert data_rvalid_o for exactly one cycle, exactly LATENCY cycles after each grant cycle, for both reads and writes.
REQ-021 SHALL return responses strictly in grant order; back-to-back grants every cycle SHALL yield rvalid every cycle.
REQ-022 SHALL drive data_rdata_o with the stored word for read responses and all-zero for write responses and idle cycles.
REQ-023 SHALL implement the latency pipeline as LATENCY stages of {valid, rdata}; in-flight responses never stall, and no response backpressure exists.

Reset
REQ-024 SHALL, while rst_ni = 0, clear all pipeline valid bits and rdata to 0, so that data_rvalid_o = 0 and data_rdata_o = 0.
REQ-025 SHALL drop responses in flight when reset is asserted mid-operation; no rvalid for pre-reset grants SHALL appear after reset is released.
REQ-026 SHALL not reset storage contents.
REQ-027 SHALL reset the stall LFSR, when present, to 8'hA5.

Configuration
REQ-028 SHALL, with macro MEM_SLAVE_GNT_STALL_EN defined, include an 8-bit Fibonacci LFSR (taps 8,6,5,4) that advances every cycle; data_gnt_o = data_req_i AND (lfsr[1:0] != 2'b00).
REQ-029 SHALL, without MEM_SLAVE_GNT_STALL_EN, omit the LFSR entirely; data_gnt_o = data_req_i.

Verification
REQ-030 SHALL verify write then read, LATENCY=2: write addr 0x10, wdata 0xDEADBEEF_CAFEF00D, be 0xFF; then read 0x10 -> rvalid 2 cycles after each grant; read rdata = 0xDEADBEEF_CAFEF00D; write rdata = 0.
REQ-031 SHALL verify a partial write: with word 0x18 = 0x11223344_55667788, write be 0x0F, wdata 0xAAAAAAAA_BBBBBBBB -> subsequent read returns 0x11223344_BBBBBBBB.
REQ-032 SHALL verify streaming: 8 back-to-back reads, req held high, no stall macro -> 8 consecutive gnt cycles and 8 consecutive rvalid cycles, in order, starting LATENCY cycles after the first grant.
REQ-033 SHALL verify wrap: NUM_WORDS=1024, write 0x1 to address 0x2000, read address 0x0 -> rdata = 0x1.
REQ-034 SHALL verify reset mid-flight: grant a read, assert rst_ni low 1 cycle later, release -> no rvalid ever appears for that read; rdata = 0 after reset.
REQ-035 SHALL verify stall, with MEM_SLAVE_GNT_STALL_EN: req held high for 32 cycles -> gnt low exactly in cycles where lfsr[1:0] = 0 (sequence from seed 0xA5); rvalid count equals grant count.
